payload_stream_arbiter: RTL and testbench
=========================================

Name: payload_stream_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the single payload aligner input among NUM_SOURCES raw packet streams.
- Holds a grant from the accepted sop beat through the accepted eop beat.
- Enforces a programmable idle gap between packets so the aligner can flush its header state.
- Drives the aligner's sop/eop/payload/byte_enable/valid inputs through one register stage; the aligner has no backpressure.

Parameters:
- NUM_SOURCES, 4, number of requesting streams (>= 2).
- GAP_CYCLES, 1, forced idle output cycles after each eop beat (0 allowed).
- SRC_ID_W, $clog2(NUM_SOURCES), width of the source id output.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  NUM_SOURCES  per-source beat valid
- in_payload  in  NUM_SOURCES*packet_width_bits  per-source beat data; source i occupies slice i
- in_byte_enable  in  NUM_SOURCES*byte_enable_width_bits  per-source byte enables, MSB = first byte
- in_sop  in  NUM_SOURCES  per-source start of packet
- in_eop  in  NUM_SOURCES  per-source end of packet
- in_ready  out  NUM_SOURCES  per-source beat accepted (combinational)
- payload_valid  out  1  beat valid to aligner
- payload  out  packet_width_bits  beat data to aligner
- byte_enable  out  byte_enable_width_bits  byte enables to aligner
- sop  out  1  start of packet to aligner
- eop  out  1  end of packet to aligner
- src_id  out  SRC_ID_W  source of the current output beat
- busy  out  1  high in PASS or GAP
- err_stray  out  NUM_SOURCES  one-cycle pulse: non-sop beat dropped while that source was ungranted
- err_proto  out  1  one-cycle pulse: sop inside a packet, or eop with all-zero byte_enable

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0; state IDLE.
  - RR pointer = NUM_SOURCES-1, so source 0 has the highest priority first.
  - Gap counter = 0.
- Handshake: a beat transfers when in_valid[i] & in_ready[i].
- Output register: each transferred granted beat appears on the aligner outputs the next cycle, with payload_valid=1 and fields copied. Latency is exactly 1 cycle.
- No transfer in a cycle -> next cycle payload_valid=sop=eop=0; payload and byte_enable hold their last values.
- IDLE:
  - req = in_valid & in_sop.
  - Winner = first set bit of req searching upward from pointer+1, wrapping at NUM_SOURCES.
  - in_ready[winner]=1 and the beat transfers. Pointer <= winner, grant <= winner.
  - Next state: PASS, or GAP if that beat also has eop.
  - Sources with in_valid & !in_sop get in_ready=1; the beat is dropped and err_stray[i] pulses the next cycle.
  - With no req, stay in IDLE.
- PASS:
  - in_ready = onehot(grant). All other sources see in_ready=0 and are held; no stray dropping.
  - Granted source idle -> output bubble; stay in PASS (no timeout).
  - Accepted eop beat -> GAP, or IDLE if GAP_CYCLES=0.
  - Accepted sop beat -> forwarded unchanged, err_proto pulses, packet continues.
- GAP:
  - in_ready = 0 for all sources. Counter loads GAP_CYCLES-1 on entry and decrements each cycle.
  - Counter 0 -> IDLE.
  - Output sees exactly GAP_CYCLES invalid cycles between an eop beat and the next sop beat.
- Byte enables:
  - On non-eop beats, output byte_enable is forced to all-ones.
  - On eop beats it is forwarded unchanged. If it is all-zero, err_proto pulses and the beat is still forwarded.
- src_id: registered with the beat, equal to grant.
- busy = (state != IDLE).
- Simultaneous events: single-beat packets (sop & eop) are handled as in IDLE above. A stray on source j and a grant to source i in the same IDLE cycle are both serviced.
- Reset mid-packet: the output is truncated immediately with no synthetic eop; after release, arbitration restarts from source 0.

Decomposition:
- payload_aligner_pkg gains: arb_state_t enum {IDLE, PASS, GAP}, and the function onehot_to_idx.
- Packet and byte widths come from the existing packet_width_bits, byte_enable_width_bits and byte_width_bits.
- Sub-module rr_picker: combinational rotate-priority-rotate over NUM_SOURCES. Inputs req and pointer; outputs winner_onehot, winner_idx and any_req. No state.

Test Plan:
- Source 2 sends a 3-beat packet, eop byte_enable=8'b1110_0000 (64-bit bus) -> output sop at t+1, three valid beats, eop beat byte_enable 8'b1110_0000, src_id=2, in_ready[0,1,3]=0 throughout.
- All 4 sources hold sop continuously after reset, 1-beat packets, GAP_CYCLES=1 -> grant order 0,1,2,3,0 with exactly one invalid output cycle between eops.
- GAP_CYCLES=3, source 1 eop then immediate sop request -> exactly 3 payload_valid=0 cycles, then sop.
- Source 3 drives valid without sop while idle -> in_ready[3]=1, nothing output, err_stray=4'b1000 for one cycle.
- Granted source 0 stalls 5 cycles mid-packet while source 1 requests -> 5 bubbles, in_ready[1]=0, no grant switch until source 0's eop.
- rst_n asserted on the second beat of a 4-beat packet -> all outputs 0 asynchronously; after release, source 0 wins over simultaneous source 0 and source 2 requests.

Source files
------------

// File: rtl/payload_aligner_pkg.sv
// Shared types and widths for the payload aligner datapath and its input arbiter.
package payload_aligner_pkg;

  localparam int unsigned byte_width_bits        = 8;
  localparam int unsigned packet_width_bits      = 64;
  localparam int unsigned byte_enable_width_bits = packet_width_bits / byte_width_bits;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  // Index of the set bit of a one-hot vector (up to 32 entries); 0 when empty.
  function automatic logic [7:0] onehot_to_idx(input logic [31:0] onehot);
    logic [7:0] idx;
    idx = 8'd0;
    for (int b = 0; b < 32; b++) begin
      if (onehot[b]) begin
        idx = idx | 8'(b);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/payload_stream_arbiter_rr_picker.sv
// Combinational round-robin picker: rotate requests so pointer+1 is bit 0,
// isolate the lowest set bit, rotate back.
module rr_picker
  import payload_aligner_pkg::*;
#(
  parameter int unsigned NUM_SOURCES = 4,
  parameter int unsigned SRC_ID_W    = $clog2(NUM_SOURCES)
) (
  input  logic [NUM_SOURCES-1:0] req,
  input  logic [SRC_ID_W-1:0]    pointer,
  output logic [NUM_SOURCES-1:0] winner_onehot,
  output logic [SRC_ID_W-1:0]    winner_idx,
  output logic                   any_req
);

  localparam logic [NUM_SOURCES-1:0] ONE_LSB = NUM_SOURCES'(1);

  logic [NUM_SOURCES-1:0] rot_s;
  logic [NUM_SOURCES-1:0] first_s;
  logic [NUM_SOURCES-1:0] unrot_s;
  int unsigned            shift_s;
  logic [SRC_ID_W-1:0]    pos_s;

  // Rotate, pick lowest request, rotate back.
  always_comb begin
    shift_s = (int'(pointer) + 1) % NUM_SOURCES;
    rot_s   = '0;
    unrot_s = '0;
    pos_s   = '0;
    for (int k = 0; k < NUM_SOURCES; k++) begin
      pos_s        = SRC_ID_W'((k + shift_s) % NUM_SOURCES);
      rot_s[k]     = req[pos_s];
    end
    first_s = rot_s & (~rot_s + ONE_LSB);
    for (int k = 0; k < NUM_SOURCES; k++) begin
      pos_s          = SRC_ID_W'((k + shift_s) % NUM_SOURCES);
      unrot_s[pos_s] = first_s[k];
    end
  end

  assign winner_onehot = unrot_s;
  assign winner_idx    = SRC_ID_W'(onehot_to_idx(32'(unrot_s)));
  assign any_req       = |req;

endmodule

// File: rtl/payload_stream_arbiter.sv
// Packet-granular round-robin arbiter feeding the payload aligner through one
// register stage, with a programmable idle gap after every packet.
module payload_stream_arbiter
  import payload_aligner_pkg::*;
#(
  parameter int unsigned NUM_SOURCES = 4,
  parameter int unsigned GAP_CYCLES  = 1,
  parameter int unsigned SRC_ID_W    = $clog2(NUM_SOURCES)
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic [NUM_SOURCES-1:0]                         in_valid,
  input  logic [NUM_SOURCES*packet_width_bits-1:0]       in_payload,
  input  logic [NUM_SOURCES*byte_enable_width_bits-1:0]  in_byte_enable,
  input  logic [NUM_SOURCES-1:0]                         in_sop,
  input  logic [NUM_SOURCES-1:0]                         in_eop,
  output logic [NUM_SOURCES-1:0]                         in_ready,
  output logic                                           payload_valid,
  output logic [packet_width_bits-1:0]                   payload,
  output logic [byte_enable_width_bits-1:0]              byte_enable,
  output logic                                           sop,
  output logic                                           eop,
  output logic [SRC_ID_W-1:0]                            src_id,
  output logic                                           busy,
  output logic [NUM_SOURCES-1:0]                         err_stray,
  output logic                                           err_proto
);

  localparam int unsigned                    GAP_W     = $clog2(GAP_CYCLES + 2);
  localparam logic [GAP_W-1:0]               GAP_LOAD  = (GAP_CYCLES > 32'd0) ? GAP_W'(GAP_CYCLES - 1) : {GAP_W{1'b0}};
  localparam logic [GAP_W-1:0]               GAP_ZERO  = {GAP_W{1'b0}};
  localparam logic [SRC_ID_W-1:0]            PTR_RESET = SRC_ID_W'(NUM_SOURCES - 1);
  localparam logic [byte_enable_width_bits-1:0] BE_ALL  = {byte_enable_width_bits{1'b1}};
  localparam logic [byte_enable_width_bits-1:0] BE_NONE = {byte_enable_width_bits{1'b0}};
  localparam logic [NUM_SOURCES-1:0]         ONE_LSB   = NUM_SOURCES'(1);
  // After an eop the packet either closes into the gap or, with no gap, straight to idle.
  localparam arb_state_t                     AFTER_EOP = (GAP_CYCLES == 32'd0) ? IDLE : GAP;

  arb_state_t                  state_r, state_nxt_s;
  logic [SRC_ID_W-1:0]         ptr_r, ptr_nxt_s;
  logic [SRC_ID_W-1:0]         grant_r, grant_nxt_s;
  logic [GAP_W-1:0]            gap_cnt_r, gap_cnt_nxt_s;

  logic [NUM_SOURCES-1:0]      win_onehot_s;
  logic [SRC_ID_W-1:0]         win_idx_s;
  logic                        any_req_s;
  logic [NUM_SOURCES-1:0]      in_ready_s;
  logic [NUM_SOURCES-1:0]      stray_drop_s;
  logic                        xfer_s;
  logic                        proto_s;

  logic [packet_width_bits-1:0]      payload_arr_s [NUM_SOURCES];
  logic [byte_enable_width_bits-1:0] be_arr_s      [NUM_SOURCES];
  logic [SRC_ID_W-1:0]               sel_idx_s;
  logic [packet_width_bits-1:0]      sel_payload_s;
  logic [byte_enable_width_bits-1:0] sel_be_s;
  logic                              sel_sop_s;
  logic                              sel_eop_s;

  logic                              payload_valid_r;
  logic [packet_width_bits-1:0]      payload_r;
  logic [byte_enable_width_bits-1:0] byte_enable_r;
  logic                              sop_r;
  logic                              eop_r;
  logic [SRC_ID_W-1:0]               src_id_r;
  logic [NUM_SOURCES-1:0]            err_stray_r;
  logic                              err_proto_r;

  for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_unpack
    assign payload_arr_s[g] = in_payload[g*packet_width_bits +: packet_width_bits];
    assign be_arr_s[g]      = in_byte_enable[g*byte_enable_width_bits +: byte_enable_width_bits];
  end

  rr_picker #(
    .NUM_SOURCES (NUM_SOURCES),
    .SRC_ID_W    (SRC_ID_W)
  ) u_rr_picker (
    .req           (in_valid & in_sop),
    .pointer       (ptr_r),
    .winner_onehot (win_onehot_s),
    .winner_idx    (win_idx_s),
    .any_req       (any_req_s)
  );

  // In IDLE the candidate beat is the picker's winner, otherwise the granted source.
  assign sel_idx_s     = (state_r == IDLE) ? win_idx_s : grant_r;
  assign sel_payload_s = payload_arr_s[sel_idx_s];
  assign sel_be_s      = be_arr_s[sel_idx_s];
  assign sel_sop_s     = in_sop[sel_idx_s];
  assign sel_eop_s     = in_eop[sel_idx_s];
  assign proto_s       = xfer_s & (((state_r == PASS) & sel_sop_s) | (sel_eop_s & (sel_be_s == BE_NONE)));

  // Next-state, grant bookkeeping and ready generation.
  always_comb begin
    state_nxt_s   = state_r;
    ptr_nxt_s     = ptr_r;
    grant_nxt_s   = grant_r;
    gap_cnt_nxt_s = gap_cnt_r;
    in_ready_s    = '0;
    stray_drop_s  = '0;
    xfer_s        = 1'b0;
    case (state_r)
      IDLE: begin
        stray_drop_s = in_valid & ~in_sop;
        in_ready_s   = win_onehot_s | stray_drop_s;
        if (any_req_s) begin
          xfer_s        = 1'b1;
          ptr_nxt_s     = win_idx_s;
          grant_nxt_s   = win_idx_s;
          gap_cnt_nxt_s = GAP_LOAD;
          state_nxt_s   = sel_eop_s ? AFTER_EOP : PASS;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PASS: begin
        in_ready_s = ONE_LSB << grant_r;
        if (in_valid[grant_r]) begin
          xfer_s        = 1'b1;
          gap_cnt_nxt_s = GAP_LOAD;
          state_nxt_s   = sel_eop_s ? AFTER_EOP : PASS;
        end else begin
          state_nxt_s = PASS;
        end
      end
      GAP: begin
        if (gap_cnt_r == GAP_ZERO) begin
          state_nxt_s = IDLE;
        end else begin
          gap_cnt_nxt_s = gap_cnt_r - GAP_W'(1);
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Arbitration state registers; pointer resets to the last source so source 0 leads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      ptr_r     <= PTR_RESET;
      grant_r   <= {SRC_ID_W{1'b0}};
      gap_cnt_r <= GAP_ZERO;
    end else begin
      state_r   <= state_nxt_s;
      ptr_r     <= ptr_nxt_s;
      grant_r   <= grant_nxt_s;
      gap_cnt_r <= gap_cnt_nxt_s;
    end
  end

  // Aligner-facing output stage; data fields hold when no beat transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      payload_valid_r <= 1'b0;
      payload_r       <= {packet_width_bits{1'b0}};
      byte_enable_r   <= BE_NONE;
      sop_r           <= 1'b0;
      eop_r           <= 1'b0;
      src_id_r        <= {SRC_ID_W{1'b0}};
      err_stray_r     <= {NUM_SOURCES{1'b0}};
      err_proto_r     <= 1'b0;
    end else begin
      payload_valid_r <= xfer_s;
      sop_r           <= xfer_s & sel_sop_s;
      eop_r           <= xfer_s & sel_eop_s;
      err_stray_r     <= stray_drop_s;
      err_proto_r     <= proto_s;
      if (xfer_s) begin
        payload_r     <= sel_payload_s;
        byte_enable_r <= sel_eop_s ? sel_be_s : BE_ALL;
        src_id_r      <= sel_idx_s;
      end
    end
  end

  assign in_ready      = in_ready_s;
  assign payload_valid = payload_valid_r;
  assign payload       = payload_r;
  assign byte_enable   = byte_enable_r;
  assign sop           = sop_r;
  assign eop           = eop_r;
  assign src_id        = src_id_r;
  assign busy          = (state_r != IDLE);
  assign err_stray     = err_stray_r;
  assign err_proto     = err_proto_r;

endmodule

// File: tb/tb_payload_stream_arbiter.sv
// Randomized bench for payload_stream_arbiter against a packet-level reference model.
module tb_payload_stream_arbiter;
  import payload_aligner_pkg::*;

  localparam int N  = 4;
  localparam int G  = 2;
  localparam int PW = packet_width_bits;
  localparam int BW = byte_enable_width_bits;
  localparam int CYCLES = 3000;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      in_valid;
  logic [N*PW-1:0]   in_payload;
  logic [N*BW-1:0]   in_byte_enable;
  logic [N-1:0]      in_sop;
  logic [N-1:0]      in_eop;
  logic [N-1:0]      in_ready;
  logic              payload_valid;
  logic [PW-1:0]     payload;
  logic [BW-1:0]     byte_enable;
  logic              sop;
  logic              eop;
  logic [1:0]        src_id;
  logic              busy;
  logic [N-1:0]      err_stray;
  logic              err_proto;

  int checks;
  int failures;

  // Source-side beat generators
  logic          v [N];
  logic          s [N];
  logic          e [N];
  logic [PW-1:0] pl [N];
  logic [BW-1:0] be [N];
  logic          acc [N];
  int            left [N];
  int            plen [N];

  // Reference model: packet owner, gap countdown and last winner
  bit            in_packet;
  int            owner;
  int            last_win;
  int            gap_left;
  logic [N-1:0]  exp_rdy;
  logic          exp_pv, exp_sop, exp_eop, exp_proto;
  logic [PW-1:0] exp_pl;
  logic [BW-1:0] exp_be;
  logic [1:0]    exp_src;
  logic [N-1:0]  exp_stray;

  payload_stream_arbiter #(.NUM_SOURCES(N), .GAP_CYCLES(G)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_payload     (in_payload),
    .in_byte_enable (in_byte_enable),
    .in_sop         (in_sop),
    .in_eop         (in_eop),
    .in_ready       (in_ready),
    .payload_valid  (payload_valid),
    .payload        (payload),
    .byte_enable    (byte_enable),
    .sop            (sop),
    .eop            (eop),
    .src_id         (src_id),
    .busy           (busy),
    .err_stray      (err_stray),
    .err_proto      (err_proto)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_value(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    in_packet = 1'b0;
    gap_left  = 0;
    owner     = 0;
    last_win  = N - 1;
    exp_pv = 1'b0; exp_sop = 1'b0; exp_eop = 1'b0; exp_proto = 1'b0;
    exp_pl = '0; exp_be = '0; exp_src = '0; exp_stray = '0;
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b0; s[i] = 1'b0; e[i] = 1'b0; pl[i] = '0; be[i] = '0;
      acc[i] = 1'b0; left[i] = 0; plen[i] = 1;
    end
  endtask

  task automatic gen_beat(input int i);
    v[i]  = ($urandom_range(0, 99) < 65);
    pl[i] = {$urandom, $urandom};
    be[i] = BW'($urandom);
    if (left[i] == 0) begin
      if ($urandom_range(0, 9) == 0) begin
        s[i] = 1'b0;
        e[i] = 1'($urandom_range(0, 1));
      end else begin
        s[i]    = 1'b1;
        plen[i] = $urandom_range(1, 4);
        e[i]    = (plen[i] == 1);
      end
    end else begin
      s[i] = ($urandom_range(0, 19) == 0);
      e[i] = (left[i] == 1);
    end
    if (e[i] && ($urandom_range(0, 7) == 0)) be[i] = '0;
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      in_valid[i]                = v[i];
      in_sop[i]                  = s[i];
      in_eop[i]                  = e[i];
      in_payload[i*PW +: PW]     = pl[i];
      in_byte_enable[i*BW +: BW] = be[i];
    end
  endtask

  task automatic check_outputs(input string pfx);
    check_value({pfx, "payload_valid"}, 64'(payload_valid), 64'(exp_pv));
    check_value({pfx, "sop"},           64'(sop),           64'(exp_sop));
    check_value({pfx, "eop"},           64'(eop),           64'(exp_eop));
    check_value({pfx, "payload"},       64'(payload),       64'(exp_pl));
    check_value({pfx, "byte_enable"},   64'(byte_enable),   64'(exp_be));
    check_value({pfx, "src_id"},        64'(src_id),        64'(exp_src));
    check_value({pfx, "err_stray"},     64'(err_stray),     64'(exp_stray));
    check_value({pfx, "err_proto"},     64'(err_proto),     64'(exp_proto));
  endtask

  // One arbitration cycle of the reference model, evaluated on the settled inputs.
  task automatic model_step();
    int win;
    int src;
    win = -1;
    src = -1;
    exp_rdy = '0;
    exp_stray = '0;
    if (gap_left > 0) begin
      src = -1;
    end else if (in_packet) begin
      exp_rdy[owner] = 1'b1;
      if (v[owner]) src = owner;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (last_win + k) % N;
        if (win < 0 && v[j] && s[j]) win = j;
      end
      if (win >= 0) exp_rdy[win] = 1'b1;
      for (int j = 0; j < N; j++) begin
        if (v[j] && !s[j]) begin
          exp_rdy[j]   = 1'b1;
          exp_stray[j] = 1'b1;
        end
      end
      src = win;
    end
    check_value("in_ready", 64'(in_ready), 64'(exp_rdy));
    check_value("busy", 64'(busy), 64'(in_packet || gap_left > 0));
    for (int j = 0; j < N; j++) acc[j] = v[j] && exp_rdy[j];

    exp_pv    = (src >= 0);
    exp_sop   = 1'b0;
    exp_eop   = 1'b0;
    exp_proto = 1'b0;
    if (gap_left > 0) begin
      gap_left--;
    end else if (src >= 0) begin
      exp_sop   = s[src];
      exp_eop   = e[src];
      exp_pl    = pl[src];
      exp_be    = e[src] ? be[src] : {BW{1'b1}};
      exp_src   = 2'(src);
      exp_proto = (in_packet && s[src]) || (e[src] && be[src] == '0);
      if (!in_packet) begin
        owner    = src;
        last_win = src;
      end
      if (s[src] && left[src] == 0) left[src] = plen[src] - 1;
      else if (left[src] > 0) left[src]--;
      in_packet = !e[src];
      if (e[src]) gap_left = G;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    in_valid = '0; in_sop = '0; in_eop = '0; in_payload = '0; in_byte_enable = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs("reset_");
    check_value("reset_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;

    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      @(negedge clk);
      check_outputs("");
      if (cyc == 1000 || cyc == 2000) begin
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("midrst_");
        check_value("midrst_busy", 64'(busy), 64'd0);
        drive_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        // Directed restart: sources 0 and 2 request together, 0 must win first.
        v[0] = 1'b1; s[0] = 1'b1; e[0] = 1'b1; pl[0] = 64'h0123_4567_89ab_cdef; be[0] = 8'hf0;
        v[2] = 1'b1; s[2] = 1'b1; e[2] = 1'b1; pl[2] = 64'hfeed_0000_beef_2222; be[2] = 8'hff;
        plen[0] = 1; plen[2] = 1;
        drive_inputs();
        #1;
        model_step();
        continue;
      end
      for (int i = 0; i < N; i++) begin
        if (!v[i] || acc[i]) gen_beat(i);
      end
      drive_inputs();
      #1;
      model_step();
    end

    @(negedge clk);
    check_outputs("final_");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
